free_slot_alloc: RTL and testbench

- Slot allocator that owns a DW-entry occupancy bitmap and hands out the lowest-index free slot on each accepted request.
- Returns slots to the pool on free requests.
- Sits in front of rename/issue-queue/ROB-style storage; the lowest-zero search is a combinational tree over the registered bitmap.
- Provides count, full/empty status, flush and a sticky misuse flag.

---
 rtl/free_slot_alloc.sv | 119 +++++++++++
 tb/tb_free_slot_alloc.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/free_slot_alloc.sv
// free_slot_alloc: keeps a DW-entry occupancy bitmap and grants the lowest
// free slot on each accepted request. Slots are returned by index. The
// allocator also provides count, full/empty status, flush and a sticky
// misuse flag.
//
// Ports
//   CLK, RST        clock; asynchronous active-high reset
//   alloc_valid_i   requester wants one slot this cycle
//   alloc_ready_o   at least one slot is free
//   alloc_idx_o     lowest free slot (0 when full)
//   free_valid_i    return slot free_idx_i this cycle
//   free_idx_i      index of the slot being returned
//   flush_i         release every slot at the next edge
//   occ_o           registered occupancy bitmap (1 = slot in use)
//   cnt_o           number of occupied slots, 0..DW
//   full_o, empty_o status derived from the registered count
//   err_o           sticky: a free named a slot that was not occupied
module free_slot_alloc #(
  parameter int CW = 4,
  parameter int DW = 2**CW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          alloc_valid_i,
  output logic          alloc_ready_o,
  output logic [CW-1:0] alloc_idx_o,
  input  logic          free_valid_i,
  input  logic [CW-1:0] free_idx_i,
  input  logic          flush_i,
  output logic [DW-1:0] occ_o,
  output logic [CW:0]   cnt_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          err_o
);

  logic [DW-1:0] occ;
  logic [CW:0]   cnt;
  logic          err;

  // Heap-ordered "has-zero" tree. Node k has children 2k and 2k+1. Node 1 is
  // the root. Leaf DW+i holds ~occ[i]. The tree depth is CW OR levels.
  logic [2*DW-1:1] hz;

  genvar gi;
  generate
    for (gi = 0; gi < DW; gi++) begin : g_leaf
      assign hz[DW+gi] = ~occ[gi];
    end
    for (gi = 1; gi < DW; gi++) begin : g_node
      assign hz[gi] = hz[2*gi] | hz[2*gi+1];
    end
  endgenerate

  // Top-down select. At each level, go left when the left subtree holds a
  // zero. After CW steps the node number is DW + index, so its low CW bits
  // are the index.
  logic [CW:0] node [CW+1];
  assign node[0] = (CW+1)'(1);

  generate
    for (gi = 0; gi < CW; gi++) begin : g_sel
      assign node[gi+1] = {node[gi][CW-1:0], ~hz[{node[gi][CW-1:0], 1'b0}]};
    end
  endgenerate

  assign alloc_ready_o = hz[1];
  // With no zero present the walk ends at the rightmost leaf. Force index 0.
  assign alloc_idx_o   = hz[1] ? node[CW][CW-1:0] : '0;

  logic alloc_fire, free_fire, free_hit, free_miss;
  assign alloc_fire = alloc_valid_i & alloc_ready_o;
  assign free_fire  = free_valid_i & ~flush_i;
  assign free_hit   = free_fire &  occ[free_idx_i];
  assign free_miss  = free_fire & ~occ[free_idx_i];

  logic [DW-1:0] occ_nxt;
  logic [CW:0]   cnt_nxt;

  always_comb begin
    occ_nxt = occ;
    cnt_nxt = cnt;
    if (flush_i) begin
      // The grant in a flush cycle is dropped. Requesters treat it as void.
      occ_nxt = '0;
      cnt_nxt = '0;
    end else begin
      // A hit frees an occupied slot. A grant always targets a free slot.
      // The two can never name the same bit. A miss on the granted slot
      // leaves the grant in place.
      if (free_hit)   occ_nxt[free_idx_i]  = 1'b0;
      if (alloc_fire) occ_nxt[alloc_idx_o] = 1'b1;
      case ({alloc_fire, free_hit})
        2'b10:   cnt_nxt = cnt + 1'b1;
        2'b01:   cnt_nxt = cnt - 1'b1;
        default: cnt_nxt = cnt;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      occ <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      occ <= occ_nxt;
      cnt <= cnt_nxt;
      if (free_miss) err <= 1'b1;
    end
  end

  assign occ_o   = occ;
  assign cnt_o   = cnt;
  assign full_o  = (cnt == (CW+1)'(DW));
  assign empty_o = (cnt == '0);
  assign err_o   = err;

endmodule

// File: tb/tb_free_slot_alloc.sv
module tb_free_slot_alloc;
  localparam int CW = 2;
  localparam int DW = 4;

  logic          CLK, RST;
  logic          alloc_valid_i, alloc_ready_o;
  logic [CW-1:0] alloc_idx_o;
  logic          free_valid_i;
  logic [CW-1:0] free_idx_i;
  logic          flush_i;
  logic [DW-1:0] occ_o;
  logic [CW:0]   cnt_o;
  logic          full_o, empty_o, err_o;

  int checks = 0;
  int errors = 0;

  free_slot_alloc #(.CW(CW), .DW(DW)) dut (
    .CLK(CLK), .RST(RST),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_idx_o(alloc_idx_o),
    .free_valid_i(free_valid_i), .free_idx_i(free_idx_i),
    .flush_i(flush_i),
    .occ_o(occ_o), .cnt_o(cnt_o), .full_o(full_o), .empty_o(empty_o),
    .err_o(err_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic st(input string tag, input logic [3:0] occ, input int cnt,
                    input logic rdy, input int idx);
    chk({tag, ".occ"}, 32'(occ_o), 32'(occ));
    chk({tag, ".cnt"}, 32'(cnt_o), cnt);
    chk({tag, ".rdy"}, 32'(alloc_ready_o), 32'(rdy));
    chk({tag, ".idx"}, 32'(alloc_idx_o), idx);
  endtask

  initial begin
    RST = 1'b1; alloc_valid_i = 0; free_valid_i = 0; free_idx_i = 0; flush_i = 0;
    #2;
    st("rst", 4'b0000, 0, 1, 0);
    chk("rst.full", 32'(full_o), 0);
    chk("rst.empty", 32'(empty_o), 1);
    chk("rst.err", 32'(err_o), 0);
    @(negedge CLK); RST = 1'b0;
    tick();

    // Fill: grants 0,1,2,3, then a 5th request while full does nothing.
    alloc_valid_i = 1;
    st("fill0", 4'b0000, 0, 1, 0);
    tick(); st("fill1", 4'b0001, 1, 1, 1);
    tick(); st("fill2", 4'b0011, 2, 1, 2);
    tick(); st("fill3", 4'b0111, 3, 1, 3);
    tick(); st("fill4", 4'b1111, 4, 0, 0);
    chk("fill4.full", 32'(full_o), 1);
    tick(); st("fill5", 4'b1111, 4, 0, 0);
    alloc_valid_i = 0;

    // Free slot 2 from full, then re-grant it.
    free_valid_i = 1; free_idx_i = 2;
    tick(); free_valid_i = 0;
    st("free2", 4'b1011, 3, 1, 2);
    chk("free2.full", 32'(full_o), 0);
    alloc_valid_i = 1;
    tick(); alloc_valid_i = 0;
    st("realloc2", 4'b1111, 4, 0, 0);

    // Reach 0111, then alloc slot 3 and free slot 0 in the same cycle.
    free_valid_i = 1; free_idx_i = 3;
    tick();
    st("pre_sim", 4'b0111, 3, 1, 3);
    alloc_valid_i = 1; free_idx_i = 0;
    tick(); alloc_valid_i = 0; free_valid_i = 0;
    st("sim", 4'b1110, 3, 1, 0);

    // Flush to empty, build 0101, then free the unoccupied slot 1.
    flush_i = 1;
    tick(); flush_i = 0;
    st("flush1", 4'b0000, 0, 1, 0);
    chk("flush1.empty", 32'(empty_o), 1);
    alloc_valid_i = 1;
    tick(); tick(); tick(); alloc_valid_i = 0;
    st("b0111", 4'b0111, 3, 1, 3);
    free_valid_i = 1; free_idx_i = 1;
    tick();
    st("b0101", 4'b0101, 2, 1, 1);
    chk("b0101.err", 32'(err_o), 0);
    tick(); free_valid_i = 0;
    st("miss", 4'b0101, 2, 1, 1);
    chk("miss.err", 32'(err_o), 1);

    // Build 1011, then flush together with an alloc fire and a free of slot 0.
    alloc_valid_i = 1;
    tick(); tick(); alloc_valid_i = 0;
    free_valid_i = 1; free_idx_i = 2;
    tick();
    st("b1011", 4'b1011, 3, 1, 2);
    alloc_valid_i = 1; free_idx_i = 0; flush_i = 1;
    tick(); alloc_valid_i = 0; free_valid_i = 0; flush_i = 0;
    st("flush2", 4'b0000, 0, 1, 0);
    chk("flush2.empty", 32'(empty_o), 1);
    chk("flush2.err", 32'(err_o), 1);

    // Fill, then assert RST between edges. State must clear without a clock edge.
    alloc_valid_i = 1;
    tick(); tick(); tick(); tick(); alloc_valid_i = 0;
    st("refill", 4'b1111, 4, 0, 0);
    #2; RST = 1'b1; #1;
    st("async", 4'b0000, 0, 1, 0);
    chk("async.full", 32'(full_o), 0);
    chk("async.empty", 32'(empty_o), 1);
    chk("async.err", 32'(err_o), 0);
    @(negedge CLK); RST = 1'b0;
    tick();
    st("post_rst", 4'b0000, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
